wb_burst_reader: RTL and testbench

//  Wishbone classic master: reads a linear memory region in fixed-length

---
 rtl/wb_burst_reader.sv | 175 +++++++++++++++++
 tb/tb_wb_burst_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// Wishbone classic read master: fetches NB_WORDS words from BASE_ADDR in
// BURST_LEN-beat bursts and delivers them through a show-ahead FIFO stream.
module wb_burst_reader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NB_WORDS   = 1024,
    parameter int                    BURST_LEN  = 8,
    parameter int                    FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_WIDTH-1:0]     adr,
    output logic                      cyc,
    output logic                      stb,
    output logic                      we,
    output logic [DATA_WIDTH/8-1:0]   sel,
    input  logic [DATA_WIDTH-1:0]     dat_sm,
    input  logic                      ack,
    input  logic                      err,
    input  logic                      rty,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int STEP  = DATA_WIDTH / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WC_W  = $clog2(NB_WORDS + 1);
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        BURST,
        GAP
    } state_t;

    state_t state, state_nxt;

    logic [WC_W-1:0]       word_cnt;
    logic [BC_W-1:0]       beat_cnt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      free_slots;
    logic                  push, pop, space_ok, last_beat, last_word;

    assign we  = 1'b0;
    assign sel = '1;

    assign rvalid     = (count != '0);
    assign rdata      = mem[rd_ptr];
    assign pop        = rvalid && rready;
    // A word leaving this cycle already counts as room for the next burst.
    assign free_slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
    assign space_ok   = (free_slots >= CNT_W'(BURST_LEN));

    assign push      = (state == BURST) && ack && !err && !rty;
    assign last_beat = (beat_cnt == BC_W'(BURST_LEN - 1));
    assign last_word = (word_cnt == WC_W'(NB_WORDS - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cyc       = 1'b0;
        stb       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                cyc = 1'b1;
                stb = 1'b1;
                // err beats rty beats ack when the slave raises several.
                if (err) begin
                    state_nxt = IDLE;
                end else if (rty) begin
                    state_nxt = GAP;
                end else if (ack) begin
                    if (last_word) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else if (last_beat) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                state_nxt = WAIT_SPACE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state-holding registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr      <= BASE_ADDR;
            word_cnt <= '0;
            beat_cnt <= '0;
            error    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                adr      <= BASE_ADDR;
                word_cnt <= '0;
                beat_cnt <= '0;
                error    <= 1'b0;
            end
        end else if (state == BURST) begin
            if (err) begin
                error <= 1'b1;
            end else if (!rty && ack) begin
                adr      <= adr + ADDR_WIDTH'(STEP);
                word_cnt <= word_cnt + WC_W'(1);
                beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define emptiness, so clearing the words would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dat_sm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: behavioural latency/burst RAM
// responder, random consumer, and an expected-word queue per pass.
module tb_wb_burst_reader;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NBW     = 32;
    localparam int BL      = 8;
    localparam int FD      = 16;
    localparam int LATENCY = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, error, cyc, stb, we, rvalid;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_sm = '0;
    logic            ack = 1'b0;
    logic            err = 1'b0;
    logic            rty = 1'b0;
    logic [DW-1:0]   rdata;
    logic            rready = 1'b0;

    wb_burst_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR('0),
        .NB_WORDS(NBW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .adr(adr), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
        .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: word i lives at byte address 4*i and holds value i. The
    // first beat of each cyc/stb run waits LATENCY cycles, later beats ack
    // back-to-back; dropping stb re-arms the latency.
    int lat = 0;
    int s_word;
    bit inj_err_en = 0;
    bit inj_rty_en = 0;
    int inj_word = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ack = 1'b0;
            err = 1'b0;
            rty = 1'b0;
            if (rst || !(cyc && stb)) begin
                lat = 0;
            end else if (lat < LATENCY) begin
                lat++;
            end else begin
                s_word = int'(adr >> 2);
                ack    = 1'b1;
                dat_sm = s_word;
                if (inj_err_en && s_word == inj_word) begin
                    err        = 1'b1;
                    inj_err_en = 0;
                    dat_sm     = 32'hDEAD_BEEF;
                end else if (inj_rty_en && s_word == inj_word) begin
                    rty        = 1'b1;
                    inj_rty_en = 0;
                    dat_sm     = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Bus monitor: transaction log plus protocol observations.
    logic [AW-1:0] ack_log[$];
    int cyc_rises = 0, seg_acks = 0, seg_viol = 0, stb_viol = 0;
    int done_cnt = 0, rty_cnt = 0;
    logic [AW-1:0] reissue_adr = '1;
    bit rty_pending = 0, prev_cyc = 0, prev_wait = 0, prev_done = 0, prev_err = 0;

    always @(negedge clk) begin
        if (prev_done) check("busy_after_done", busy, 0);
        if (prev_err)  check("cyc_after_err", cyc, 0);
        if (prev_wait && !stb && !rst) stb_viol++;
        if (cyc && !prev_cyc) begin
            cyc_rises++;
            seg_acks = 0;
            if (rty_pending) begin
                reissue_adr = adr;
                rty_pending = 0;
            end
        end
        if (cyc && stb && ack && !err && !rty) begin
            ack_log.push_back(adr);
            seg_acks++;
            if (seg_acks > BL) seg_viol++;
        end
        if (cyc && stb && rty && !err) begin
            rty_cnt++;
            rty_pending = 1;
        end
        if (done) done_cnt++;
        prev_done = done;
        prev_err  = cyc && stb && err;
        prev_wait = cyc && stb && !ack && !err && !rty && !rst;
        prev_cyc  = cyc;
    end

    // Consumer: pops against the expected-word queue of the current pass.
    int rready_mode = 1;
    int exp_q[$];

    always @(negedge clk) begin
        case (rready_mode)
            0:       rready = 1'b0;
            1:       rready = 1'b1;
            default: rready = ($urandom_range(3) != 0);
        endcase
        if (rvalid && rready && !rst) begin
            if (exp_q.size() == 0) check("stream_extra", rvalid, 0);
            else                   check("stream", rdata, exp_q.pop_front());
        end
    end

    task automatic load_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (!busy && !rvalid && exp_q.size() == 0) break;
        end
        check({tag, "_timeout"}, n < 6000, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic verify_acks(input string tag, input int a0, input int n);
        check({tag, "_acks"}, ack_log.size() - a0, n);
        for (int i = 0; i < n && a0 + i < ack_log.size(); i++)
            check({tag, "_ack_adr"}, ack_log[a0 + i], 4 * i);
    endtask

    int a0, r0, d0, q0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_adr", adr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_we", we, 0);
        check("rst_sel", sel, 4'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic pass, always ready
        rready_mode = 1;
        a0 = ack_log.size(); r0 = cyc_rises; d0 = done_cnt;
        load_exp(NBW);
        pulse_start();
        check("t1_busy", busy, 1);
        wait_idle("t1");
        verify_acks("t1", a0, NBW);
        check("t1_bursts", cyc_rises - r0, 4);
        check("t1_done", done_cnt - d0, 1);

        // 2: backpressure fills the FIFO, then drains at random rate
        rready_mode = 0;
        a0 = ack_log.size(); d0 = done_cnt;
        load_exp(NBW);
        pulse_start();
        repeat (300) @(negedge clk);
        check("t2_acks_stalled", ack_log.size() - a0, 16);
        check("t2_cyc_stalled", cyc, 0);
        check("t2_busy_stalled", busy, 1);
        check("t2_rvalid", rvalid, 1);
        rready_mode = 2;
        wait_idle("t2");
        verify_acks("t2", a0, NBW);
        check("t2_done", done_cnt - d0, 1);

        // 3: retry on the third beat of the first burst
        rready_mode = 2;
        a0 = ack_log.size(); r0 = cyc_rises; d0 = done_cnt; q0 = rty_cnt;
        inj_word = 2; inj_rty_en = 1;
        load_exp(NBW);
        pulse_start();
        wait_idle("t3");
        check("t3_rty_seen", rty_cnt - q0, 1);
        check("t3_reissue_adr", reissue_adr, 8);
        check("t3_bursts", cyc_rises - r0, 5);
        verify_acks("t3", a0, NBW);
        check("t3_done", done_cnt - d0, 1);

        // 4: error on word 10 aborts; a new start clears error
        rready_mode = 2;
        a0 = ack_log.size(); d0 = done_cnt;
        inj_word = 10; inj_err_en = 1;
        load_exp(10);
        pulse_start();
        wait_idle("t4");
        check("t4_error", error, 1);
        check("t4_no_done", done_cnt - d0, 0);
        verify_acks("t4", a0, 10);
        a0 = ack_log.size(); d0 = done_cnt;
        load_exp(NBW);
        pulse_start();
        check("t4_error_cleared", error, 0);
        wait_idle("t4b");
        verify_acks("t4b", a0, NBW);
        check("t4b_done", done_cnt - d0, 1);

        // 5: asynchronous reset in the middle of the second burst
        rready_mode = 1;
        a0 = ack_log.size();
        load_exp(NBW);
        pulse_start();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (ack_log.size() - a0 >= 10 && cyc) break;
        end
        check("t5_reached_burst2", ack_log.size() - a0 >= 10, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_cyc", cyc, 0);
        check("t5_stb", stb, 0);
        check("t5_rvalid", rvalid, 0);
        check("t5_busy", busy, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rready_mode = 2;
        a0 = ack_log.size(); d0 = done_cnt;
        load_exp(NBW);
        pulse_start();
        wait_idle("t5");
        verify_acks("t5", a0, NBW);
        check("t5_done", done_cnt - d0, 1);

        // 6: start pulses during a pass are ignored
        rready_mode = 2;
        a0 = ack_log.size(); r0 = cyc_rises; d0 = done_cnt;
        load_exp(NBW);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(5, 30)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_idle("t6");
        verify_acks("t6", a0, NBW);
        check("t6_bursts", cyc_rises - r0, 4);
        check("t6_done", done_cnt - d0, 1);

        check("stb_dropped_early", stb_viol, 0);
        check("burst_too_long", seg_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
